// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// circular prefetch buffer, with redirect flush and drain of stale responses.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               pc_en,
    input  logic               fd_en,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               instr_valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_q, fetch_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic [ADDR_W-1:0]  addr_d, pcout_d;
    logic [INSTR_W-1:0] instr_d;
    logic               req_d, valid_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic               ack_v, push, pop, can_issue;

    logic [ADDR_W-1:0]  buf_pc  [DEPTH];
    logic [INSTR_W-1:0] buf_ins [DEPTH];

    // Buffer bookkeeping; redirect flushes and overrides push/pop
    always_comb begin
        ack_v  = imem_req & imem_ack;
        push   = ack_v & (state_q == WAIT) & ~redirect;
        pop    = instr_valid & fd_en & ~redirect;
        occ_d  = occ_q + CNT_W'(push) - CNT_W'(pop);
        rd_d   = rd_q + PTR_W'(pop);
        wr_d   = wr_q + PTR_W'(push);
        last_d = pop ? pc_out : last_q;
        if (redirect) begin
            occ_d = '0;
            rd_d  = '0;
            wr_d  = '0;
        end
        // A new request is only issued if a slot remains after this cycle
        can_issue = pc_en & (occ_d < CNT_W'(DEPTH));
    end

    // Next state and request outputs
    always_comb begin
        state_d = state_q;
        fetch_d = redirect ? redirect_pc : fetch_q;
        req_d   = imem_req;
        addr_d  = imem_addr;
        unique case (state_q)
            IDLE: begin
                if (can_issue) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    addr_d  = fetch_d;
                end
            end
            WAIT, DRAIN: begin
                if (ack_v) begin
                    if (push) fetch_d = fetch_q + ADDR_W'(4);
                    if (can_issue) begin
                        state_d = WAIT;
                        req_d   = 1'b1;
                        addr_d  = fetch_d;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Next head of buffer; a push into an empty buffer bypasses storage
    always_comb begin
        valid_d = (occ_d != '0);
        instr_d = NOP;
        pcout_d = last_d;
        if (valid_d) begin
            if (push && (occ_d == CNT_W'(1))) begin
                instr_d = imem_rdata;
                pcout_d = fetch_q;
            end else begin
                instr_d = buf_ins[rd_d];
                pcout_d = buf_pc[rd_d];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_q     <= RESET_PC;
            last_q      <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            occ_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            instr_valid <= 1'b0;
            instr_out   <= NOP;
            pc_out      <= RESET_PC;
        end else begin
            fetch_q     <= fetch_d;
            last_q      <= last_d;
            imem_req    <= req_d;
            imem_addr   <= addr_d;
            occ_q       <= occ_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            instr_valid <= valid_d;
            instr_out   <= instr_d;
            pc_out      <= pcout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_q]  <= fetch_q;
            buf_ins[wr_q] <= imem_rdata;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!nrst)
        push |-> (occ_q < CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        pc_en = 1'b0, fd_en = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr_out, pc_out;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit dut (
        .clk         (clk),
        .nrst        (nrst),
        .pc_en       (pc_en),
        .fd_en       (fd_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // Reference model: buffer contents as a queue, one outstanding request
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        q[$];
    bit          m_busy, m_drain;
    logic [31:0] m_addr, m_fetch, m_last;

    task automatic model_reset();
        q.delete();
        m_busy  = 1'b0;
        m_drain = 1'b0;
        m_addr  = RESET_PC;
        m_fetch = RESET_PC;
        m_last  = RESET_PC;
    endtask

    task automatic model_step(input bit pe, input bit fe, input bit ack,
                              input bit rd, input logic [31:0] rpc);
        bit   ack_v;
        ent_t e;
        ack_v = m_busy && ack;
        if (!rd && fe && q.size() > 0) begin
            m_last = q[0].pc;
            void'(q.pop_front());
        end
        if (rd) q.delete();
        if (ack_v) begin
            if (!m_drain && !rd) begin
                e.pc  = m_addr;
                e.ins = mem_word(m_addr);
                q.push_back(e);
                m_fetch = m_addr + 32'd4;
            end
            m_busy  = 1'b0;
            m_drain = 1'b0;
        end else if (m_busy && rd) begin
            m_drain = 1'b1;
        end
        if (rd) m_fetch = rpc;
        if (!m_busy && pe && q.size() < DEPTH) begin
            m_busy = 1'b1;
            m_addr = m_fetch;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        bit v;
        v = (q.size() != 0);
        check({tag, " req"}, 32'(imem_req), 32'(m_busy));
        if (m_busy) check({tag, " addr"}, imem_addr, m_addr);
        check({tag, " valid"}, 32'(instr_valid), 32'(v));
        check({tag, " instr"}, instr_out, v ? q[0].ins : NOP);
        check({tag, " pc"}, pc_out, v ? q[0].pc : m_last);
    endtask

    task automatic cycle(input bit pe, input bit fe, input bit ack, input bit rd,
                         input logic [31:0] rpc, input string tag);
        @(negedge clk);
        check_model(tag);
        pc_en = pe; fd_en = fe; imem_ack = ack; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        model_step(pe, fe, ack, rd, rpc);
    endtask

    typedef struct {
        bit          pe, fe, ack;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_val;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 12;
    vec_t tv [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected outputs are sampled before the row's inputs are applied
        tv[0]  = '{1, 1, 0, 0, 32'h00, 0, 32'h00};
        tv[1]  = '{1, 1, 1, 1, 32'h00, 0, 32'h00};
        tv[2]  = '{1, 1, 1, 1, 32'h04, 1, 32'h00};
        tv[3]  = '{1, 1, 1, 1, 32'h08, 1, 32'h04};
        tv[4]  = '{1, 1, 0, 1, 32'h0C, 1, 32'h08};
        tv[5]  = '{1, 0, 1, 1, 32'h0C, 0, 32'h08};
        tv[6]  = '{1, 0, 1, 1, 32'h10, 1, 32'h0C};
        tv[7]  = '{1, 0, 1, 0, 32'h00, 1, 32'h0C};
        tv[8]  = '{1, 0, 0, 0, 32'h00, 1, 32'h0C};
        tv[9]  = '{1, 1, 0, 0, 32'h00, 1, 32'h0C};
        tv[10] = '{1, 0, 1, 1, 32'h14, 1, 32'h10};
        tv[11] = '{1, 0, 0, 0, 32'h00, 1, 32'h10};

        model_reset();
        repeat (2) @(negedge clk);
        check("rst req", 32'(imem_req), 32'd0);
        check("rst addr", imem_addr, RESET_PC);
        check("rst valid", 32'(instr_valid), 32'd0);
        check("rst instr", instr_out, NOP);
        check("rst pc", pc_out, RESET_PC);
        nrst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d req", i), 32'(imem_req), 32'(tv[i].e_req));
            if (tv[i].e_req) check($sformatf("vec%0d addr", i), imem_addr, tv[i].e_addr);
            check($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(tv[i].e_val));
            check($sformatf("vec%0d pc", i), pc_out, tv[i].e_pc);
            check($sformatf("vec%0d instr", i), instr_out,
                  tv[i].e_val ? mem_word(tv[i].e_pc) : NOP);
            pc_en = tv[i].pe; fd_en = tv[i].fe; imem_ack = tv[i].ack;
            redirect = 1'b0; redirect_pc = '0;
            @(posedge clk);
            model_step(tv[i].pe, tv[i].fe, tv[i].ack, 1'b0, 32'h0);
        end

        // Redirect while a request awaits its ack: stale data must be dropped
        cycle(1, 1, 0, 1, 32'h0000_0008, "rd_issue8");
        cycle(1, 1, 0, 1, 32'h0000_0100, "rd_to100");
        cycle(1, 1, 0, 0, 32'h0, "drain1");
        cycle(1, 1, 0, 0, 32'h0, "drain2");
        #1;
        check("drain hold req", 32'(imem_req), 32'd1);
        check("drain hold addr", imem_addr, 32'h0000_0008);
        cycle(1, 1, 1, 0, 32'h0, "drain_ack");
        #1;
        check("post drain addr", imem_addr, 32'h0000_0100);
        check("post drain valid", 32'(instr_valid), 32'd0);

        // Redirect coinciding with ack and pop
        cycle(1, 0, 1, 0, 32'h0, "fill100");
        cycle(1, 1, 1, 1, 32'h0000_0200, "rd_ack_pop");
        #1;
        check("rap valid", 32'(instr_valid), 32'd0);
        check("rap instr", instr_out, NOP);
        check("rap req", 32'(imem_req), 32'd1);
        check("rap addr", imem_addr, 32'h0000_0200);

        // Address wrap at the top of the space
        cycle(1, 1, 0, 1, 32'hFFFF_FFFC, "rd_top");
        cycle(1, 1, 1, 0, 32'h0, "top_drain_ack");
        #1;
        check("top addr", imem_addr, 32'hFFFF_FFFC);
        cycle(1, 1, 1, 0, 32'h0, "top_ack");
        #1;
        check("wrap addr", imem_addr, 32'h0000_0000);

        // Asynchronous reset in the middle of an outstanding request
        @(negedge clk);
        check_model("pre_reset");
        pc_en = 1'b0; fd_en = 1'b0; imem_ack = 1'b0; redirect = 1'b0;
        nrst = 1'b0;
        #1;
        check("mid rst req", 32'(imem_req), 32'd0);
        check("mid rst addr", imem_addr, RESET_PC);
        check("mid rst valid", 32'(instr_valid), 32'd0);
        check("mid rst instr", instr_out, NOP);
        check("mid rst pc", pc_out, RESET_PC);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        cycle(1, 1, 0, 0, 32'h0, "post_rst");
        #1;
        check("post rst req", 32'(imem_req), 32'd1);
        check("post rst addr", imem_addr, RESET_PC);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            bit          pe, fe, ack, rd;
            logic [31:0] rpc;
            pe  = ($urandom % 8) != 0;
            fe  = ($urandom % 3) != 0;
            ack = ($urandom % 2) != 0;
            rd  = ($urandom % 20) == 0;
            if (($urandom % 4) == 0)
                rpc = 32'hFFFF_FFF0 + (32'($urandom_range(3, 0)) << 2);
            else
                rpc = $urandom & 32'hFFFF_FFFC;
            cycle(pe, fe, ack, rd, rpc, "rand");
        end
        @(negedge clk);
        check_model("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and memory address width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have parameter DEPTH, default 2, prefetch buffer entries, power of two, at least 2.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port nrst  in  1  reset, asynchronous assertion, active-low.
REQ-007 SHALL have port pc_en  in  1  fetch enable (PC_ENABLE bit of control word); low blocks new memory requests.
REQ-008 SHALL have port fd_en  in  1  downstream accepts current instruction (FD_REG_EN).
REQ-009 SHALL have port redirect  in  1  mispredict/jump redirect, one-cycle pulse.
REQ-010 SHALL have port redirect_pc  in  ADDR_W  target address, valid with redirect.
REQ-011 SHALL have port imem_req  out  1  instruction memory request.
REQ-012 SHALL have port imem_addr  out  ADDR_W  request address.
REQ-013 SHALL have port imem_ack  in  1  memory response; the transfer completes in the cycle where imem_req and imem_ack are both high.
REQ-014 SHALL have port imem_rdata  in  INSTR_W  instruction data, valid with imem_ack.
REQ-015 SHALL have port instr_out  out  INSTR_W  instruction to decode (instr_in of control unit).
REQ-016 SHALL have port pc_out  out  ADDR_W  address of instr_out.
REQ-017 SHALL have port instr_valid  out  1  buffer head valid.

Function
REQ-018 SHALL keep the FSM states IDLE (no request), WAIT (request outstanding), and DRAIN (outstanding response to discard after redirect).
REQ-019 SHALL keep at most one outstanding request; imem_req high only in WAIT and DRAIN, imem_addr and imem_req stable until ack.
REQ-020 SHALL move IDLE->WAIT, driving imem_req the same cycle, when pc_en=1 and slots = DEPTH - occupancy - (request in flight) > 0.
REQ-021 SHALL on ack in WAIT push {fetch_pc, imem_rdata} into the buffer, advance fetch_pc by 4 modulo 2^ADDR_W, and stay in WAIT with the new address (back-to-back) if the REQ-020 condition holds for the next cycle, else go to IDLE.
REQ-022 SHALL present pushed data on instr_out/pc_out with instr_valid=1 one cycle after the ack edge (registered FIFO write).
REQ-023 SHALL pop the head on instr_valid=1 and fd_en=1; a simultaneous push and pop keeps occupancy unchanged; the circular pointers wrap modulo DEPTH.
REQ-024 SHALL drive instr_out = 32'h00000013 (NOP) and pc_out = last popped PC when instr_valid=0.
REQ-025 SHALL never push when full; the REQ-020 slot accounting guarantees this, and a push on full is an assertion error.
REQ-026 SHALL on redirect=1 flush the buffer (occupancy 0, instr_valid=0 next cycle) and load fetch_pc <= redirect_pc, with priority over push and pop in that cycle.
REQ-027 SHALL on redirect in WAIT without ack go to DRAIN; on redirect with ack the same cycle, discard the data and go to IDLE/WAIT at redirect_pc.
REQ-028 SHALL in DRAIN keep imem_req high at the old address until ack, discard that data without pushing or advancing fetch_pc, then go to IDLE (or to WAIT at redirect_pc if REQ-020 holds).
REQ-029 SHALL on a second redirect in DRAIN overwrite fetch_pc with the newest redirect_pc and remain in DRAIN.
REQ-030 SHALL let an outstanding request complete normally when pc_en drops; pc_en affects only the issue of new requests.
REQ-031 SHALL ignore imem_ack while imem_req=0.

Reset
REQ-032 SHALL on nrst=0 set immediately state=IDLE, fetch_pc=RESET_PC, occupancy=0, pointers=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=NOP, pc_out=RESET_PC.
REQ-033 SHALL abandon any outstanding request when reset is asserted mid-operation; the first request after reset release is issued at RESET_PC in the first cycle with nrst=1 and pc_en=1.

Verification
REQ-034 SHALL cover: reset release, pc_en=1, memory acks after 1 cycle, fd_en=1 -> addresses 0,4,8 issued back-to-back, instr_out matches per PC with 1-cycle post-ack latency.
REQ-035 SHALL cover: fd_en=0 for 6 cycles -> exactly DEPTH=2 entries buffered (PC 0,4), imem_req low, no third request until a pop.
REQ-036 SHALL cover: redirect to 0x100 while request at 0x8 awaits ack (ack 3 cycles later) -> DRAIN, data for 0x8 never appears, next imem_addr=0x100.
REQ-037 SHALL cover: redirect to 0x200 in the same cycle as ack and pop -> buffer empty next cycle, instr_out=NOP, next request 0x200.
REQ-038 SHALL cover: fetch_pc=0xFFFFFFFC acked -> next imem_addr=0x0 (wrap).
REQ-039 SHALL cover: nrst pulsed low mid-WAIT -> all outputs at REQ-032 values immediately, first post-reset imem_addr=RESET_PC.
